// File: rtl/parameters.sv
// IJTAG trim-fuse-override TDR: scan/update shadow plus a settle FSM that flags trim_out invalid while a new trim value settles.
// Optional scan parity bit and sticky par_err are compiled in with `define TRIM_OVR_PARITY_EN.
module parameters #(
    parameter int TRIM_WIDTH    = 16,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  ijtag_tck,
    input  logic                  ijtag_reset,
    input  logic                  ijtag_sel,
    input  logic                  ijtag_si,
    input  logic                  ijtag_ce,
    input  logic                  ijtag_se,
    input  logic                  ijtag_ue,
    output logic                  ijtag_so,
    input  logic [TRIM_WIDTH-1:0] fuse_trim_in,
    output logic [TRIM_WIDTH-1:0] trim_out,
    output logic                  trim_valid,
    output logic                  ovr_active,
    output logic                  par_err
);

`ifdef TRIM_OVR_PARITY_EN
    localparam int L = TRIM_WIDTH + 2;
`else
    localparam int L = TRIM_WIDTH + 1;
`endif
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_SETTLE
    } state_t;

    logic [L-1:0]          r_sr;
    logic                  r_shadow_en;
    logic [TRIM_WIDTH-1:0] r_shadow_data;
    logic [L-1:0]          w_capture;
    logic                  w_update_ok;

    state_t                r_state, w_state_nxt;
    logic [TRIM_WIDTH-1:0] r_pending, w_pending_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic [TRIM_WIDTH-1:0] r_trim_out, w_trim_nxt;
    logic                  r_trim_valid, w_valid_nxt;
    logic [TRIM_WIDTH-1:0] w_target;

    // The parity bit captures the sticky error so the tester can read it back.
`ifdef TRIM_OVR_PARITY_EN
    logic r_par_err;

    assign w_update_ok = ~(^r_sr);
    assign w_capture   = {r_par_err, r_shadow_en, r_trim_out};
    assign par_err     = r_par_err;

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            r_par_err <= 1'b0;
        end else if (ijtag_sel && !ijtag_ce && !ijtag_se && ijtag_ue) begin
            r_par_err <= ^r_sr;
        end
    end
`else
    assign w_update_ok = 1'b1;
    assign w_capture   = {r_shadow_en, r_trim_out};
    assign par_err     = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            r_sr          <= '0;
            r_shadow_en   <= 1'b0;
            r_shadow_data <= '0;
        end else if (ijtag_sel) begin
            if (ijtag_ce) begin
                r_sr <= w_capture;
            end else if (ijtag_se) begin
                r_sr <= {ijtag_si, r_sr[L-1:1]};
            end else if (ijtag_ue && w_update_ok) begin
                {r_shadow_en, r_shadow_data} <= r_sr[TRIM_WIDTH:0];
            end
        end
    end

    assign w_target = r_shadow_en ? r_shadow_data : fuse_trim_in;

    // NOTE: every next-state variable gets a default first so no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_cnt_nxt     = r_cnt;
        w_trim_nxt    = r_trim_out;
        w_valid_nxt   = r_trim_valid;
        case (r_state)
            ST_IDLE: begin
                if (w_target != r_trim_out) begin
                    w_state_nxt   = ST_SETTLE;
                    w_pending_nxt = w_target;
                    w_cnt_nxt     = CNT_RELOAD;
                    w_valid_nxt   = 1'b0;
                end
            end
            ST_SETTLE: begin
                // A target that moves mid-window restarts the full settle time.
                if (w_target != r_pending) begin
                    w_pending_nxt = w_target;
                    w_cnt_nxt     = CNT_RELOAD;
                end else if (r_cnt == '0) begin
                    w_trim_nxt  = r_pending;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = ST_SETTLE;
        endcase
    end

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            r_state      <= ST_SETTLE;
            r_pending    <= '0;
            r_cnt        <= CNT_RELOAD;
            r_trim_out   <= '0;
            r_trim_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pending    <= w_pending_nxt;
            r_cnt        <= w_cnt_nxt;
            r_trim_out   <= w_trim_nxt;
            r_trim_valid <= w_valid_nxt;
        end
    end

    assign ijtag_so   = r_sr[0];
    assign trim_out   = r_trim_out;
    assign trim_valid = r_trim_valid;
    assign ovr_active = r_shadow_en;

endmodule

// File: doc/parameters.md
# firebird7_in_gate1_tessent_tdr_trim_fuse_override

IJTAG test data register (TDR) that sits directly downstream of the trim-fuse-override SIB. Its scan input comes from that SIB's host path, and its scan output returns to the SIB's from-SO input. It holds an override enable and an override trim word in an update shadow. It drives the analog trim bus either from the fuse value or from the override. Every change of the effective trim value goes through a settle window during which the trim bus is flagged invalid.

## Interface
Parameters:
- TRIM_WIDTH, 16, width of trim word (≥2)
- SETTLE_CYCLES, 4, cycles trim_valid stays low before a new trim value is applied (≥1)

Ports:
- ijtag_tck  in  1  sole clock, all state on rising edge
- ijtag_reset  in  1  reset, synchronous, active-high
- ijtag_sel  in  1  segment select, from upstream SIB to-sel
- ijtag_si  in  1  scan in
- ijtag_ce  in  1  capture enable
- ijtag_se  in  1  shift enable
- ijtag_ue  in  1  update enable
- ijtag_so  out  1  scan out, fed to SIB from-SO
- fuse_trim_in  in  TRIM_WIDTH  functional fuse trim value
- trim_out  out  TRIM_WIDTH  applied trim value
- trim_valid  out  1  trim_out stable and applied
- ovr_active  out  1  shadow override enable
- par_err  out  1  sticky parity error; constant 0 when parity is compiled out

## Operation
- Scan register sr length L = TRIM_WIDTH+1, or TRIM_WIDTH+2 with parity.
  - sr[TRIM_WIDTH-1:0] = data; sr[TRIM_WIDTH] = ovr_en; sr[TRIM_WIDTH+1] = parity bit (parity build only).
  - ijtag_so = sr[0], combinational from the flop. No retiming, because the SIB retimes.
- Port operations, gated by ijtag_sel. Priority ce > se > ue:
  - Capture: data ← trim_out, ovr_en ← shadow_en, parity bit ← par_err.
  - Shift: sr ← {ijtag_si, sr[L-1:1]}.
  - Update: {shadow_en, shadow_data} ← sr, subject to the parity check.
- With sel=0, sr and the shadow hold.
- target = shadow_en ? shadow_data : fuse_trim_in (combinational).
- Settle FSM, states IDLE and SETTLE, with a pending register and counter cnt:
  - IDLE, target == trim_out: hold.
  - IDLE, target ≠ trim_out: → SETTLE; pending ← target; cnt ← SETTLE_CYCLES-1; trim_valid ← 0.
  - SETTLE, target ≠ pending: pending ← target; cnt ← SETTLE_CYCLES-1 (window restarts).
  - SETTLE, target == pending and cnt == 0: trim_out ← pending; trim_valid ← 1; → IDLE.
  - SETTLE, otherwise: cnt ← cnt-1.
- ovr_active = shadow_en (registered).

## Timing
- Reset values:
  - sr = 0, shadow_en = 0, shadow_data = 0, par_err = 0.
  - trim_out = 0, trim_valid = 0, ijtag_so = 0, ovr_active = 0.
  - State = SETTLE, pending = 0, cnt = SETTLE_CYCLES-1.
- Reset at any point, including mid-shift or mid-settle, aborts the operation. The first post-reset edge evaluates target normally.
- Shadow is visible one edge after the ue edge.
- Latency from the update edge to trim_out/trim_valid high is SETTLE_CYCLES+1 edges. trim_valid is low for exactly SETTLE_CYCLES cycles when target changes only once.
- An update that leaves target unchanged causes no settle and no trim_valid drop.
- trim_out changes only on the same edge on which trim_valid rises. It never changes while trim_valid = 1.
- fuse_trim_in changes while shadow_en = 0 follow the same settle path. While shadow_en = 1 they are ignored.
- Shift of L bits followed by ue: the first bit shifted in lands in sr[0].

## Configuration
- TRIM_OVR_PARITY_EN defined:
  - sr gains the parity bit; an update is valid only if the XOR of all L bits is 0.
  - A bad update leaves the shadow unchanged and sets par_err.
  - A good update clears par_err.
- Undefined:
  - L = TRIM_WIDTH+1 and every update is accepted.
  - par_err tied to 0.

## Test plan
- Reset held 2 cycles, fuse_trim_in = 0x1234 → trim_out = 0 and trim_valid = 0 until edge SETTLE_CYCLES after reset release; then trim_out = 0x1234 and trim_valid = 1.
- Shift ovr_en = 1 with data = 0xA5A5 (17 bits, LSB first), then ue → ovr_active = 1 the next edge; trim_valid low for 4 cycles; then trim_out = 0xA5A5.
- While shadow_en = 1, toggle fuse_trim_in → trim_out and trim_valid unchanged. Clear override → trim_out returns to fuse_trim_in after settle.
- Second update to 0x5A5A two cycles into a settle window → window restarts; trim_out goes straight from old value to 0x5A5A with no intermediate value.
- Capture with ijtag_sel = 1, then shift out → ijtag_so streams trim_out LSB first, then ovr_en. With ijtag_sel = 0, capture, shift and update have no effect.
- (TRIM_OVR_PARITY_EN) Update with odd parity → shadow unchanged and par_err = 1; captured parity bit reads 1. Next even-parity update → shadow loads and par_err = 0.
